// File: rtl/ram_arbiter_2p.sv
// Two-requester round-robin arbiter for a single-port RAM; 1-cycle read latency, combinational grant.
// Optional post-reset zero-fill guarded by RAM_ARB_CLEAR_EN (busy high while clearing, no grants).
// Backpressure: each requester holds its request until px_ready; responses are never stalled.
module ram_arbiter_2p #(
    parameter int AW = 1,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          p0_valid,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_ready,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_valid,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_ready,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_d,
    output logic          ram_we,
    input  logic [DW-1:0] ram_q,
    output logic          busy
);

    typedef enum logic {ST_CLEAR, ST_SERVE} state_t;

`ifdef RAM_ARB_CLEAR_EN
    localparam state_t RST_STATE = ST_CLEAR;
`else
    localparam state_t RST_STATE = ST_SERVE;
`endif

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic          gnt0, gnt1;
    logic          rvalid0_q, rvalid1_q;
    logic [DW-1:0] rdata0_q, rdata1_q;

`ifdef RAM_ARB_CLEAR_EN
    logic [AW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        ram_addr = '0;
        ram_d    = '0;
        ram_we   = 1'b0;
        busy     = 1'b0;
`ifdef RAM_ARB_CLEAR_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
`ifdef RAM_ARB_CLEAR_EN
            ST_CLEAR: begin
                busy     = 1'b1;
                ram_we   = rst_n;
                ram_addr = cnt_q;
                cnt_d    = cnt_q + AW'(1);
                if (cnt_q == '1) state_d = ST_SERVE;
            end
`endif
            ST_SERVE: begin
                // rst_n gating keeps a request from being accepted while reset is held
                gnt0 = rst_n & p0_valid & (~p1_valid | last_q);
                gnt1 = rst_n & p1_valid & (~p0_valid | ~last_q);
                if (gnt0) begin
                    ram_addr = p0_addr;
                    ram_d    = p0_wdata;
                    ram_we   = p0_we;
                    last_d   = 1'b0;
                end else if (gnt1) begin
                    ram_addr = p1_addr;
                    ram_d    = p1_wdata;
                    ram_we   = p1_we;
                    last_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rvalid0_q <= gnt0 & ~p0_we;
            rvalid1_q <= gnt1 & ~p1_we;
            if (gnt0 && !p0_we) rdata0_q <= ram_q;
            if (gnt1 && !p1_we) rdata1_q <= ram_q;
        end
    end

    assign p0_ready  = gnt0;
    assign p1_ready  = gnt1;
    assign p0_rvalid = rvalid0_q;
    assign p1_rvalid = rvalid1_q;
    assign p0_rdata  = rdata0_q;
    assign p1_rdata  = rdata1_q;

endmodule

// File: tb/tb_ram_arbiter_2p.sv
// Directed bench for ram_arbiter_2p (AW=1, DW=8) with a behavioural single-port RAM.
// Builds with or without RAM_ARB_CLEAR_EN.
module tb_ram_arbiter_2p;
    localparam int AW = 1;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          p0_valid, p0_we, p1_valid, p1_we;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic          p0_ready, p0_rvalid, p1_ready, p1_rvalid;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_d, ram_q;
    logic          ram_we, busy;

    logic [DW-1:0] mem [2**AW];
    int            n_chk  = 0;
    int            n_pass = 0;

`ifdef RAM_ARB_CLEAR_EN
    localparam logic BUSY_RST = 1'b1;
`else
    localparam logic BUSY_RST = 1'b0;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_d;
    assign ram_q = mem[ram_addr];

    ram_arbiter_2p #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_valid(p0_valid), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ready(p0_ready), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_valid(p1_valid), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ready(p1_ready), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .ram_addr(ram_addr), .ram_d(ram_d), .ram_we(ram_we), .ram_q(ram_q),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv0(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        p0_valid = v; p0_we = we; p0_addr = a; p0_wdata = d;
    endtask

    task automatic drv1(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        p1_valid = v; p1_we = we; p1_addr = a; p1_wdata = d;
    endtask

    task automatic chk_ram(input string tag, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        chk({tag, "_we"}, 32'(ram_we), 32'(we));
        chk({tag, "_addr"}, 32'(ram_addr), 32'(a));
        chk({tag, "_d"}, 32'(ram_d), 32'(d));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_p0_ready"}, 32'(p0_ready), 0);
        chk({tag, "_p0_rvalid"}, 32'(p0_rvalid), 0);
        chk({tag, "_p0_rdata"}, 32'(p0_rdata), 0);
        chk({tag, "_p1_rvalid"}, 32'(p1_rvalid), 0);
        chk({tag, "_busy"}, 32'(busy), 32'(BUSY_RST));
        chk_ram(tag, 1'b0, '0, '0);
    endtask

    initial begin
        mem[0] = 8'hEE;
        mem[1] = 8'hEE;
        rst_n = 1'b0;
        // write request held during reset must not reach the RAM
        drv0(1'b1, 1'b1, 1, 8'h77);
        drv1(1'b0, 1'b0, 0, 8'h00);
        tick(); tick();
        chk_reset("rst");
        drv0(1'b0, 1'b0, 0, 8'h00);
        rst_n = 1'b1;

`ifdef RAM_ARB_CLEAR_EN
        drv0(1'b1, 1'b0, 0, 8'h00);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("clr_busy", 32'(busy), 1);
            chk("clr_ready", 32'(p0_ready), 0);
            chk_ram("clr", 1'b1, AW'(i), 8'h00);
            tick();
        end
        @(negedge clk);
        chk("clr_done_busy", 32'(busy), 0);
        chk("clr_rd0_ready", 32'(p0_ready), 1);
        tick();
        drv0(1'b1, 1'b0, 1, 8'h00);
        @(negedge clk);
        chk("clr_rd0_rvalid", 32'(p0_rvalid), 1);
        chk("clr_rd0_rdata", 32'(p0_rdata), 8'h00);
        tick();
        drv0(1'b0, 1'b0, 0, 8'h00);
        @(negedge clk);
        chk("clr_rd1_rvalid", 32'(p0_rvalid), 1);
        chk("clr_rd1_rdata", 32'(p0_rdata), 8'h00);
        tick();
`else
        @(negedge clk);
        chk("noclr_busy", 32'(busy), 0);
        tick();
`endif

        // single-port writes then reads
        drv0(1'b1, 1'b1, 0, 8'h00);
        @(negedge clk);
        chk("wr0_ready", 32'(p0_ready), 1);
        chk_ram("wr0", 1'b1, 0, 8'h00);
        tick();
        drv0(1'b1, 1'b1, 1, 8'h01);
        @(negedge clk);
        chk_ram("wr1", 1'b1, 1, 8'h01);
        chk("wr_no_rvalid", 32'(p0_rvalid), 0);
        tick();
        drv0(1'b1, 1'b0, 0, 8'h00);
        @(negedge clk);
        chk("rd0_ready", 32'(p0_ready), 1);
        chk("rd0_we", 32'(ram_we), 0);
        tick();
        drv0(1'b1, 1'b0, 1, 8'h00);
        @(negedge clk);
        chk("rd0_rvalid", 32'(p0_rvalid), 1);
        chk("rd0_rdata", 32'(p0_rdata), 8'h00);
        tick();
        drv0(1'b0, 1'b0, 0, 8'h00);
        @(negedge clk);
        chk("rd1_rvalid", 32'(p0_rvalid), 1);
        chk("rd1_rdata", 32'(p0_rdata), 8'h01);
        tick();
        @(negedge clk);
        chk("idle_rvalid", 32'(p0_rvalid), 0);
        chk("idle_rdata_hold", 32'(p0_rdata), 8'h01);
        chk_ram("idle", 1'b0, 0, 8'h00);

        // cross-port read-after-write
        drv1(1'b1, 1'b1, 1, 8'hA5);
        @(negedge clk);
        chk("raw_p1_ready", 32'(p1_ready), 1);
        chk_ram("raw_wr", 1'b1, 1, 8'hA5);
        tick();
        drv1(1'b0, 1'b0, 0, 8'h00);
        drv0(1'b1, 1'b0, 1, 8'h00);
        @(negedge clk);
        chk("raw_p0_ready", 32'(p0_ready), 1);
        tick();
        drv0(1'b0, 1'b0, 0, 8'h00);
        @(negedge clk);
        chk("raw_p0_rvalid", 32'(p0_rvalid), 1);
        chk("raw_p0_rdata", 32'(p0_rdata), 8'hA5);
        chk("raw_p1_rvalid", 32'(p1_rvalid), 0);
        tick();

        // contention after p0 was last: p1 wins, held p0 goes next
        drv0(1'b1, 1'b0, 1, 8'h00);
        drv1(1'b1, 1'b1, 0, 8'h3C);
        @(negedge clk);
        chk("hold_p1_ready", 32'(p1_ready), 1);
        chk("hold_p0_ready", 32'(p0_ready), 0);
        chk_ram("hold", 1'b1, 0, 8'h3C);
        tick();
        drv1(1'b0, 1'b0, 0, 8'h00);
        @(negedge clk);
        chk("hold_p0_next", 32'(p0_ready), 1);
        chk_ram("hold_p0", 1'b0, 1, 8'h00);
        tick();
        drv0(1'b0, 1'b0, 0, 8'h00);
        drv1(1'b1, 1'b0, 0, 8'h00);
        @(negedge clk);
        chk("hold_p0_rdata", 32'(p0_rdata), 8'hA5);
        chk("solo_p1_ready", 32'(p1_ready), 1);
        tick();

        // tie fairness: p1 was last, so p0,p1,p0,p1
        drv0(1'b1, 1'b0, 1, 8'h00);
        drv1(1'b1, 1'b0, 0, 8'h00);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("tie_p0_ready", 32'(p0_ready), 32'(k % 2 == 0));
            chk("tie_p1_ready", 32'(p1_ready), 32'(k % 2 == 1));
            chk("tie_p0_rvalid", 32'(p0_rvalid), 32'(k % 2 == 1));
            chk("tie_p1_rvalid", 32'(p1_rvalid), 32'(k % 2 == 0));
            chk("tie_addr", 32'(ram_addr), 32'((k % 2 == 0) ? 1 : 0));
            tick();
        end
        drv0(1'b0, 1'b0, 0, 8'h00);
        drv1(1'b0, 1'b0, 0, 8'h00);
        @(negedge clk);
        chk("tie_end_p0_rvalid", 32'(p0_rvalid), 0);
        chk("tie_end_p1_rvalid", 32'(p1_rvalid), 1);
        chk("tie_p0_rdata", 32'(p0_rdata), 8'hA5);
        chk("tie_p1_rdata", 32'(p1_rdata), 8'h3C);
        tick();

        // reset one cycle after a read accept
        drv0(1'b1, 1'b0, 0, 8'h00);
        @(negedge clk);
        chk("mid_rd_ready", 32'(p0_ready), 1);
        tick();
        chk("mid_rvalid_pre", 32'(p0_rvalid), 1);
        rst_n = 1'b0;
        #1;
        chk_reset("mid_rst");
        tick();
        drv0(1'b0, 1'b0, 0, 8'h00);
        tick();
        rst_n = 1'b1;
`ifdef RAM_ARB_CLEAR_EN
        @(negedge clk);
        chk("reclr_busy", 32'(busy), 1);
        chk_ram("reclr0", 1'b1, 0, 8'h00);
        tick();
        @(negedge clk);
        chk_ram("reclr1", 1'b1, 1, 8'h00);
        tick();
        drv0(1'b1, 1'b0, 0, 8'h00);
        @(negedge clk);
        chk("reclr_ready", 32'(p0_ready), 1);
        tick();
        drv0(1'b0, 1'b0, 0, 8'h00);
        @(negedge clk);
        chk("reclr_rdata", 32'(p0_rdata), 8'h00);
`else
        drv0(1'b1, 1'b0, 0, 8'h00);
        @(negedge clk);
        chk("rerst_ready", 32'(p0_ready), 1);
        tick();
        drv0(1'b0, 1'b0, 0, 8'h00);
        @(negedge clk);
        chk("rerst_rvalid", 32'(p0_rvalid), 1);
`endif
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ram_arbiter_2p.md
# ram_arbiter_2p

Two-requester arbiter and sequencer for a single-port DFF RAM macro (RAM2x8 and wider members of the family). Accepts independent read/write requests from two masters, serializes them onto the RAM's single clk/D/Q/addr/we port with round-robin fairness, and returns read data with a fixed one-cycle latency. An optional post-reset sequencer zero-fills the RAM before service starts.

## Interface
Parameters:
- AW, 1, RAM address width; depth is 2^AW words.
- DW, 8, RAM data width.

Ports (x = 0, 1 for each requester):
- clk  in  1  single clock; also drives the RAM clk.
- rst_n  in  1  asynchronous, active-low reset.
- px_valid  in  1  request present.
- px_we  in  1  1 = write, 0 = read.
- px_addr  in  AW  word address.
- px_wdata  in  DW  write data.
- px_ready  out  1  request accepted this cycle (combinational grant).
- px_rvalid  out  1  one-cycle pulse; px_rdata valid.
- px_rdata  out  DW  registered read data.
- ram_addr  out  AW  to RAM addr.
- ram_d  out  DW  to RAM D.
- ram_we  out  1  to RAM we.
- ram_q  in  DW  from RAM Q; read is combinational from ram_addr.
- busy  out  1  clear sequence in progress.

## Operation
- States: CLEAR (only when RAM_ARB_CLEAR_EN defined), SERVE.
- A transfer on port x occurs in a cycle where px_valid & px_ready are both high. The requester holds valid, we, addr and wdata stable until accepted.
- SERVE grant:
  - One requester valid: that requester is granted.
  - Both valid: grant the requester not granted most recently.
  - Pointer `last` updates only on an accepted transfer.
  - Reset value of `last` is 1, so port 0 wins the first tie.
- In SERVE, the RAM is driven combinationally from the granted port: ram_addr = px_addr, ram_d = px_wdata, ram_we = px_we & grant. With no grant: ram_we = 0, ram_addr = 0, ram_d = 0.
- Read accepted on port x in cycle n: ram_q is captured at the closing edge of cycle n. In cycle n+1, px_rdata holds that value and px_rvalid = 1. px_rdata holds its value until the next read on that port.
- Write accepted: no response pulse.
- There is no backpressure on responses.
- CLEAR:
  - An AW-bit counter steps from 0 to 2^AW-1 with ram_we = 1, ram_d = 0, ram_addr = counter.
  - busy = 1 and both px_ready = 0 throughout.
  - After the last address is written, the FSM moves to SERVE.
- Read-after-write: a write in cycle n is visible to any read accepted in cycle n+1 or later, on either port.

## Timing
- Reset (rst_n low, asynchronous):
  - px_ready = 0, px_rvalid = 0, px_rdata = 0.
  - ram_we = 0 (gated by rst_n), ram_addr = 0, ram_d = 0.
  - Counter = 0, last = 1.
  - busy = 1 if RAM_ARB_CLEAR_EN is defined, else 0.
- First edge after release:
  - With RAM_ARB_CLEAR_EN: CLEAR runs for exactly 2^AW cycles (2 cycles for AW = 1). The first grant can occur in cycle 2^AW after release.
  - Without it: a grant can occur in the first cycle after release.
- Read latency: 1 cycle, accept to rvalid.
- Throughput: one transfer per cycle total. A continuously contending pair alternates 0,1,0,1.
- Reset asserted mid-CLEAR or mid-SERVE:
  - Pending rvalid is dropped.
  - CLEAR restarts from address 0 on release.
  - A transfer in the reset cycle is not performed.

## Configuration
- RAM_ARB_CLEAR_EN defined: CLEAR state, counter and busy logic are compiled in, and the RAM reads 0 at every address before the first grant.
- RAM_ARB_CLEAR_EN undefined: FSM reset state is SERVE, busy is tied 0, and RAM contents after reset are undefined.

## Test plan
- Post-reset clear (EN defined, AW = 1):
  - Release rst_n.
  - Expect busy = 1 for 2 cycles with ram_we = 1 at addr 0 then 1, and ready = 0 throughout.
  - Then p0 reads addr 0 and addr 1 → rdata 0x00 twice.
- Single-port write/read:
  - p0 writes 0x00 @0 and 0x01 @1.
  - p0 reads @0 then @1 → p0_rvalid pulses in the cycle after each accept, with rdata 0x00 then 0x01.
- Tie fairness:
  - p0 and p1 both hold valid reads for 4 cycles.
  - Grants go p0, p1, p0, p1.
  - Each port's rvalid lags its grant by exactly 1 cycle.
- Cross-port read-after-write:
  - p1 writes 0xA5 @1 in cycle n.
  - p0 reads @1, accepted in cycle n+1 → p0_rdata = 0xA5 in cycle n+2.
- Hold under contention:
  - p1 valid write 0x3C @0 while p0 was granted last.
  - p1_ready = 1 the same cycle, and ram_we/ram_d/ram_addr = 1/0x3C/0.
  - p0 request held stable is granted in the following cycle.
- Reset mid-operation:
  - Assert rst_n low one cycle after a p0 read accept.
  - Expect p0_rvalid = 0 immediately, and all outputs at their reset values.
  - With EN defined, CLEAR restarts at addr 0.
